// File: rtl/rtc_pkg.sv
// Shared RTC bus definitions: register map, transfer commands, group codes,
// default strobe timing and the write-list helpers used by the RTC controllers.
package rtc_pkg;

    localparam logic [7:0] REG_SS   = 8'h21;
    localparam logic [7:0] REG_MM   = 8'h22;
    localparam logic [7:0] REG_HH   = 8'h23;
    localparam logic [7:0] REG_DAY  = 8'h24;
    localparam logic [7:0] REG_MES  = 8'h25;
    localparam logic [7:0] REG_YEAR = 8'h26;
    localparam logic [7:0] REG_DOW  = 8'h27;
    localparam logic [7:0] REG_SS_T = 8'h41;
    localparam logic [7:0] REG_MM_T = 8'h42;
    localparam logic [7:0] REG_HH_T = 8'h43;

    localparam logic [7:0] CMD_XFER_CLOCK = 8'hF1;
    localparam logic [7:0] CMD_XFER_TIMER = 8'hF2;

    localparam int DEF_T_SETUP  = 2;
    localparam int DEF_T_STROBE = 4;
    localparam int DEF_T_HOLD   = 2;

    typedef enum logic [1:0] {
        MODE_NONE  = 2'd0,
        MODE_TIME  = 2'd1,
        MODE_DATE  = 2'd2,
        MODE_TIMER = 2'd3
    } cfg_mode_t;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_RUN,
        SEQ_GAP,
        SEQ_DONE
    } seq_state_t;

    typedef enum logic [2:0] {
        W_IDLE,
        W_A_SETUP,
        W_A_STROBE,
        W_A_HOLD,
        W_D_SETUP,
        W_D_STROBE,
        W_D_HOLD
    } wr_state_t;

    typedef struct packed {
        logic [7:0] ss;
        logic [7:0] mm;
        logic [7:0] hh;
        logic [7:0] day;
        logic [7:0] mes;
        logic [7:0] year;
        logic [7:0] dow;
        logic [7:0] ss_t;
        logic [7:0] mm_t;
        logic [7:0] hh_t;
    } cfg_bytes_t;

    function automatic logic [2:0] last_idx(cfg_mode_t m);
        return (m == MODE_DATE) ? 3'd4 : 3'd3;
    endfunction

    // {address, data} of entry idx in the group's write list.
    function automatic logic [15:0] write_pair(cfg_mode_t m, logic [2:0] idx, cfg_bytes_t b);
        logic [15:0] p;
        p = 16'h0000;
        case (m)
            MODE_TIME: begin
                case (idx)
                    3'd0:    p = {REG_SS, b.ss};
                    3'd1:    p = {REG_MM, b.mm};
                    3'd2:    p = {REG_HH, b.hh};
                    default: p = {CMD_XFER_CLOCK, 8'h00};
                endcase
            end
            MODE_DATE: begin
                case (idx)
                    3'd0:    p = {REG_DAY, b.day};
                    3'd1:    p = {REG_MES, b.mes};
                    3'd2:    p = {REG_YEAR, b.year};
                    3'd3:    p = {REG_DOW, b.dow};
                    default: p = {CMD_XFER_CLOCK, 8'h00};
                endcase
            end
            MODE_TIMER: begin
                case (idx)
                    3'd0:    p = {REG_SS_T, b.ss_t};
                    3'd1:    p = {REG_MM_T, b.mm_t};
                    3'd2:    p = {REG_HH_T, b.hh_t};
                    default: p = {CMD_XFER_TIMER, 8'h00};
                endcase
            end
            default: p = 16'h0000;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/ciclo_escritura_rtc.sv
// Single RTC bus write: address phase then data phase, each setup/strobe/hold.
// Latency: bus driven the cycle after go; ack in the last data-hold cycle.
// Backpressure: go is only honoured while idle; the caller waits for ack.
module ciclo_escritura_rtc
    import rtc_pkg::*;
#(
    parameter int T_SETUP  = DEF_T_SETUP,
    parameter int T_STROBE = DEF_T_STROBE,
    parameter int T_HOLD   = DEF_T_HOLD
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    input  logic [7:0] addr,
    input  logic [7:0] data,
    output logic       ack,
    output logic       cs_n,
    output logic       wr_n,
    output logic       a_d_n,
    output logic [7:0] ad_out,
    output logic       ad_oe
);

    localparam int CNT_W = 8;

    wr_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       data_q;

    function automatic logic [CNT_W-1:0] phase_len(wr_state_t s);
        case (s)
            W_A_SETUP,  W_D_SETUP:  return CNT_W'(T_SETUP - 1);
            W_A_STROBE, W_D_STROBE: return CNT_W'(T_STROBE - 1);
            W_A_HOLD,   W_D_HOLD:   return CNT_W'(T_HOLD - 1);
            default:                return '0;
        endcase
    endfunction

    always_comb begin
        state_nxt = state;
        ack       = 1'b0;
        case (state)
            W_IDLE:     if (go) state_nxt = W_A_SETUP;
            W_A_SETUP:  if (cnt == '0) state_nxt = W_A_STROBE;
            W_A_STROBE: if (cnt == '0) state_nxt = W_A_HOLD;
            W_A_HOLD:   if (cnt == '0) state_nxt = W_D_SETUP;
            W_D_SETUP:  if (cnt == '0) state_nxt = W_D_STROBE;
            W_D_STROBE: if (cnt == '0) state_nxt = W_D_HOLD;
            W_D_HOLD: begin
                if (cnt == '0) begin
                    state_nxt = W_IDLE;
                    ack       = 1'b1;
                end
            end
            default: state_nxt = W_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every bus pin is a flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= W_IDLE;
            cnt    <= '0;
            data_q <= 8'h00;
            cs_n   <= 1'b1;
            wr_n   <= 1'b1;
            a_d_n  <= 1'b0;
            ad_out <= 8'h00;
            ad_oe  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                cnt <= phase_len(state_nxt);
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            cs_n  <= (state_nxt == W_IDLE);
            ad_oe <= (state_nxt != W_IDLE);
            wr_n  <= !((state_nxt == W_A_STROBE) || (state_nxt == W_D_STROBE));
            // ad_out/a_d_n move only on setup entry and hold their value otherwise.
            if (state == W_IDLE && go) begin
                data_q <= data;
                ad_out <= addr;
                a_d_n  <= 1'b0;
            end else if (state == W_A_HOLD && state_nxt == W_D_SETUP) begin
                ad_out <= data_q;
                a_d_n  <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/escritor_config_rtc.sv
// Commits a configuration group (time/date/timer) to the RTC as a list of bus writes.
// Latency: bus active the cycle after start; one idle gap cycle between writes.
// Backpressure: start is dropped unless idle; busy tells the bus mux we own it.
module escritor_config_rtc
    import rtc_pkg::*;
#(
    parameter int T_SETUP  = DEF_T_SETUP,
    parameter int T_STROBE = DEF_T_STROBE,
    parameter int T_HOLD   = DEF_T_HOLD
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] config_mode,
    input  logic [7:0] data_SS,
    input  logic [7:0] data_MM,
    input  logic [7:0] data_HH,
    input  logic [7:0] data_DAY,
    input  logic [7:0] data_MES,
    input  logic [7:0] data_YEAR,
    input  logic [7:0] dia_semana,
    input  logic [7:0] data_SS_T,
    input  logic [7:0] data_MM_T,
    input  logic [7:0] data_HH_T,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       a_d_n,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       busy,
    output logic       done
);

    seq_state_t state, state_nxt;
    cfg_mode_t  mode_q, cur_mode;
    cfg_bytes_t snap_q, live, cur;
    logic [2:0] idx_q, go_idx;
    logic [15:0] pair;
    logic       accept, go, ack;

    assign live = '{ss: data_SS, mm: data_MM, hh: data_HH,
                    day: data_DAY, mes: data_MES, year: data_YEAR, dow: dia_semana,
                    ss_t: data_SS_T, mm_t: data_MM_T, hh_t: data_HH_T};

    assign accept = (state == SEQ_IDLE) && start && (config_mode != 2'd0);
    assign go     = accept || (state == SEQ_GAP);
    assign rd_n   = 1'b1;

    // The first write launches in the same edge as the snapshot, so it reads the live inputs.
    always_comb begin
        cur      = snap_q;
        cur_mode = mode_q;
        go_idx   = idx_q + 3'd1;
        if (state == SEQ_IDLE) begin
            cur      = live;
            cur_mode = cfg_mode_t'(config_mode);
            go_idx   = 3'd0;
        end
    end

    assign pair = write_pair(cur_mode, go_idx, cur);

    always_comb begin
        state_nxt = state;
        case (state)
            SEQ_IDLE: if (accept) state_nxt = SEQ_RUN;
            SEQ_RUN:  if (ack) state_nxt = (idx_q == last_idx(mode_q)) ? SEQ_DONE : SEQ_GAP;
            SEQ_GAP:  state_nxt = SEQ_RUN;
            SEQ_DONE: state_nxt = SEQ_IDLE;
            default:  state_nxt = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= SEQ_IDLE;
            mode_q <= MODE_NONE;
            snap_q <= '0;
            idx_q  <= 3'd0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == SEQ_RUN) || (state_nxt == SEQ_GAP);
            done  <= (state_nxt == SEQ_DONE);
            if (accept) begin
                mode_q <= cfg_mode_t'(config_mode);
                snap_q <= live;
                idx_q  <= 3'd0;
            end else if (state == SEQ_GAP) begin
                idx_q <= go_idx;
            end
        end
    end

    ciclo_escritura_rtc #(
        .T_SETUP (T_SETUP),
        .T_STROBE(T_STROBE),
        .T_HOLD  (T_HOLD)
    ) u_ciclo (
        .clk   (clk),
        .reset (reset),
        .go    (go),
        .addr  (pair[15:8]),
        .data  (pair[7:0]),
        .ack   (ack),
        .cs_n  (cs_n),
        .wr_n  (wr_n),
        .a_d_n (a_d_n),
        .ad_out(ad_out),
        .ad_oe (ad_oe)
    );

endmodule
